// File: rtl/transpose_pingpong_buffer.sv
// Two-bank NxN transpose buffer: rows in, columns out (row order per bank when TRANSPOSE_BYPASS_EN and i_bypass on row 0).
// Latency: first column valid the cycle after the last row of a block is accepted.
// Backpressure: o_ready low while the write bank is FULL; o_valid/o_data held while i_ready is low.
module transpose_pingpong_buffer #(
  parameter int N      = 8,
  parameter int DATA_W = 12
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [N*DATA_W-1:0] i_data,
`ifdef TRANSPOSE_BYPASS_EN
  input  logic                i_bypass,
`endif
  output logic                o_valid,
  input  logic                i_ready,
  output logic [N*DATA_W-1:0] o_data
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [DATA_W-1:0] mem [2][N][N];
  logic [1:0]        bank_full;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [IDX_W-1:0]  wr_row;
  logic [IDX_W-1:0]  rd_col;
  logic              wr_fire;
  logic              rd_fire;
  logic              rd_bypass;

  // A bank is only written while EMPTY and only read while FULL, so the two
  // pointers can never collide on the same bank in one cycle.
  assign o_ready = i_rst && !bank_full[wr_ptr];
  assign o_valid = bank_full[rd_ptr];
  assign wr_fire = i_valid && o_ready;
  assign rd_fire = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      bank_full <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      wr_row    <= '0;
      rd_col    <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_row == LAST_IDX) begin
          bank_full[wr_ptr] <= 1'b1;
          wr_row            <= '0;
          wr_ptr            <= ~wr_ptr;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_col == LAST_IDX) begin
          bank_full[rd_ptr] <= 1'b0;
          rd_col            <= '0;
          rd_ptr            <= ~rd_ptr;
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end
    end
  end

  // Storage is deliberately not reset; FULL flags alone decide what is live.
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      for (int k = 0; k < N; k++) begin
        mem[wr_ptr][wr_row][k] <= i_data[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef TRANSPOSE_BYPASS_EN
  logic [1:0] bank_bypass;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      bank_bypass <= '0;
    end else if (wr_fire && (wr_row == '0)) begin
      bank_bypass[wr_ptr] <= i_bypass;
    end
  end

  assign rd_bypass = bank_bypass[rd_ptr];
`else
  assign rd_bypass = 1'b0;
`endif

  for (genvar k = 0; k < N; k++) begin : g_col
    logic [DATA_W-1:0] elem;
    assign elem = rd_bypass ? mem[rd_ptr][rd_col][k] : mem[rd_ptr][k][rd_col];
    assign o_data[k*DATA_W +: DATA_W] = o_valid ? elem : '0;
  end

endmodule

// File: tb/tb_transpose_pingpong_buffer.sv
// Scoreboard bench for transpose_pingpong_buffer (N=8, DATA_W=12); bypass stimulus under TRANSPOSE_BYPASS_EN.
module tb_transpose_pingpong_buffer;
  localparam int N      = 8;
  localparam int DATA_W = 12;
  localparam int W      = N * DATA_W;
`ifdef TRANSPOSE_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  logic         i_clk    = 1'b0;
  logic         i_rst    = 1'b0;
  logic         i_valid  = 1'b0;
  logic         i_ready  = 1'b0;
  logic         i_bypass = 1'b0;
  logic [W-1:0] i_data   = '0;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rows[N];
  int           wr_cnt     = 0;
  logic         blk_byp    = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;
  bit           rnd_done   = 1'b0;

  transpose_pingpong_buffer #(.N(N), .DATA_W(DATA_W)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
`ifdef TRANSPOSE_BYPASS_EN
    .i_bypass(i_bypass),
`endif
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_row(input int blk, input int r);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[k*DATA_W +: DATA_W] = DATA_W'(blk*256 + 16*r + k);
    return v;
  endfunction

  // Reference model: collect accepted rows, emit the expected beats per block.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      wr_cnt     = 0;
      prev_stall = 1'b0;
      exp_q.delete();
    end else begin
      if (prev_stall) begin
        chk("hold_valid", W'(o_valid), W'(1));
        chk("hold_data", o_data, prev_data);
      end
      if (o_valid === 1'b0) chk("idle_zero", o_data, '0);
      if (o_valid && i_ready) begin
        chk("sb_nonempty", W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) chk("beat", o_data, exp_q.pop_front());
      end
      if (i_valid && o_ready) begin
        if (wr_cnt == 0) blk_byp = BYP_EN && i_bypass;
        rows[wr_cnt] = i_data;
        wr_cnt++;
        if (wr_cnt == N) begin
          for (int c = 0; c < N; c++) begin
            logic [W-1:0] e;
            for (int k = 0; k < N; k++)
              e[k*DATA_W +: DATA_W] = blk_byp ? rows[c][k*DATA_W +: DATA_W]
                                              : rows[k][c*DATA_W +: DATA_W];
            exp_q.push_back(e);
          end
          wr_cnt = 0;
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
    end
  end

  task automatic send_row(input logic [W-1:0] d, input logic byp);
    bit acc = 1'b0;
    i_valid  = 1'b1;
    i_data   = d;
    i_bypass = byp;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
    end
    chk("row_accept", W'(acc), W'(1));
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge i_clk);
    #1;
    chk("drain", W'(exp_q.size()), '0);
  endtask

  initial begin
    // Reset: o_ready low while held, idle outputs after release
    repeat (3) begin
      @(negedge i_clk);
      chk("rst_ready_low", W'(o_ready), '0);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", W'(o_ready), W'(1));
    chk("rst_valid", W'(o_valid), '0);
    chk("rst_data", o_data, '0);

    // Single block, latency and transposed pattern 16*k+c
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    for (int r = 0; r < N; r++) begin
      i_valid = 1'b1;
      i_data  = mk_row(0, r);
      @(negedge i_clk);
      if (r == N - 1) chk("s1_pre_valid", W'(o_valid), '0);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    for (int c = 0; c < N; c++) begin
      logic [W-1:0] e;
      for (int k = 0; k < N; k++) e[k*DATA_W +: DATA_W] = DATA_W'(16*k + c);
      @(negedge i_clk);
      chk("s1_valid", W'(o_valid), W'(1));
      chk("s1_beat", o_data, e);
      @(posedge i_clk); #1;
    end
    drain();

    // Four back-to-back blocks: no bubbles either side
    for (int cyc = 0; cyc < 5*N; cyc++) begin
      if (cyc < 4*N) begin
        i_valid = 1'b1;
        i_data  = mk_row(1 + cyc/N, cyc%N);
      end else begin
        i_valid = 1'b0;
      end
      @(negedge i_clk);
      if (cyc < 4*N) chk("s2_ready", W'(o_ready), W'(1));
      if (cyc >= N) chk("s2_valid", W'(o_valid), W'(1));
      @(posedge i_clk); #1;
    end
    drain();

    // Downstream stall for 20 cycles; second block fills, extra rows dropped
    i_ready = 1'b0;
    for (int r = 0; r < N; r++) send_row(mk_row(5, r), 1'b0);
    for (int s = 0; s < 20; s++) begin
      if (s < N) begin
        i_valid = 1'b1;
        i_data  = mk_row(6, s);
      end else if (s < N + 4) begin
        i_valid = 1'b1;
        i_data  = mk_row(15, s);
      end else begin
        i_valid = 1'b0;
      end
      @(negedge i_clk);
      chk("s3_valid", W'(o_valid), W'(1));
      if (exp_q.size() != 0) chk("s3_hold_col0", o_data, exp_q[0]);
      if (s < N) chk("s3_ready_hi", W'(o_ready), W'(1));
      else       chk("s3_ready_low", W'(o_ready), '0);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    drain();

    // Reset after three rows; the following eight rows form the first block
    for (int r = 0; r < 3; r++) send_row(mk_row(7, r), 1'b0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("s4_rst_ready", W'(o_ready), '0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("s4_ready", W'(o_ready), W'(1));
    chk("s4_valid", W'(o_valid), '0);
    @(posedge i_clk); #1;
    for (int r = 0; r < N; r++) send_row(mk_row(8, r), 1'b0);
    drain();

    // Random data with gaps on both sides
    rnd_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          for (int r = 0; r < N; r++) begin
            repeat ($urandom_range(0, 2)) begin
              i_valid = 1'b0;
              @(posedge i_clk); #1;
            end
            send_row({$urandom, $urandom, $urandom}, 1'b0);
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge i_clk); #1;
          i_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    i_ready = 1'b1;
    drain();

`ifdef TRANSPOSE_BYPASS_EN
    // Bypass sampled on row 0 only: first block row order, second transposed
    for (int r = 0; r < N; r++) send_row(mk_row(9, r), r == 0);
    for (int r = 0; r < N; r++) send_row(mk_row(10, r), r != 0);
    drain();
`endif

    chk("final_empty", W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/transpose_pingpong_buffer.md
TRANSPOSE_PINGPONG_BUFFER -- requirements
Module: transpose_pingpong_buffer

Interface
REQ-001 SHALL have parameter N, default 8, block dimension (rows = columns = N, N >= 2).
REQ-002 SHALL have parameter DATA_W, default 12, signed element width in bits.
REQ-003 SHALL have port i_clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_valid, input, 1 bit: input row present.
REQ-006 SHALL have port o_ready, output, 1 bit: block can accept an input row.
REQ-007 SHALL have port i_data, input, N*DATA_W bits: one row; element k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port o_valid, output, 1 bit: output column present.
REQ-009 SHALL have port i_ready, input, 1 bit: downstream accepts the output column.
REQ-010 SHALL have port o_data, output, N*DATA_W bits: one column, packed as in REQ-007.

Function
REQ-011 SHALL hold two NxN banks (B0, B1); each bank is EMPTY or FULL.
REQ-012 SHALL accept a row on the cycle where i_valid && o_ready, writing it to row wr_row of the write bank, then wr_row increments.
REQ-013 SHALL, on accepting row N-1: set the write bank FULL, reset wr_row to 0, and toggle the write-bank pointer.
REQ-014 SHALL drive o_ready = 1 iff the write bank is EMPTY and i_rst is high; no combinational path from i_valid to o_ready.
REQ-015 SHALL assert o_valid iff the read bank is FULL; element k of o_data = bank[row k][column rd_col].
REQ-016 SHALL, on o_valid && i_ready, increment rd_col; on the handshake at rd_col = N-1, set the read bank EMPTY, reset rd_col to 0, and toggle the read-bank pointer.
REQ-017 SHALL hold o_data and o_valid stable while o_valid && !i_ready.
REQ-018 SHALL drive o_data to all zeros whenever o_valid is 0.
REQ-019 SHALL assert o_valid for column 0 on the cycle after row N-1 is accepted, provided the read bank was otherwise idle (latency 1 cycle).
REQ-020 SHALL sustain one row in and one column out per cycle indefinitely when i_valid and i_ready stay high, with no bubbles after the first block.
REQ-021 SHALL allow a write to one bank and a read from the other bank in the same cycle.
REQ-022 SHALL, when a bank is freed in cycle t, make it writable (o_ready high) from cycle t+1.
REQ-023 SHALL hold o_ready low when both banks are FULL and drop any i_valid rows presented then.
REQ-024 SHALL tolerate gaps in i_valid mid-block: partially written block waits, wr_row retained, no timeout or flush.
REQ-025 SHALL store data unmodified (no sign or width conversion).

Reset
REQ-026 SHALL, while i_rst = 0 at a clock edge, set both banks EMPTY, both pointers to B0, wr_row = 0, rd_col = 0.
REQ-027 SHALL give outputs after reset: o_valid = 0, o_data = 0, o_ready = 1 (o_ready = 0 while i_rst is low).
REQ-028 SHALL discard partially written or partially read blocks on reset mid-operation; bank contents need not be cleared.

Configuration
REQ-029 SHALL, with macro TRANSPOSE_BYPASS_EN defined, add input port i_bypass (1 bit), sampled with row 0 of each block and stored per bank.
REQ-030 SHALL, with TRANSPOSE_BYPASS_EN defined and the stored bypass bit = 1, output that bank in row order (output beat c = input row c); timing and handshake are unchanged.
REQ-031 SHALL, without TRANSPOSE_BYPASS_EN, omit i_bypass and always transpose.

Verification (N=8, DATA_W=12)
REQ-032 SHALL cover: reset, then 8 rows with element(r,k) = 16*r+k, i_ready = 1 -> o_valid on the cycle after row 7 is accepted; beat c element k = 16*k+c; 8 beats.
REQ-033 SHALL cover: 4 consecutive blocks with i_valid = 1 and i_ready = 1 -> o_ready never drops, o_valid continuous from cycle 9 for 32 beats, all values correct.
REQ-034 SHALL cover: i_ready = 0 for 20 cycles after block 0 completes -> o_data held at column 0; block 1 fills; o_ready = 0 after row 7 of block 1; no data loss.
REQ-035 SHALL cover: i_rst = 0 for 1 cycle after 3 rows of block 0 -> o_ready = 1 and o_valid = 0; the next 8 rows form the first output block.
REQ-036 SHALL cover: with TRANSPOSE_BYPASS_EN, i_bypass = 1 on row 0 -> beat c element k = 16*c+k; the following block with i_bypass = 0 is transposed.
